// File: rtl/control_sequencer.sv
// control_sequencer: hardwired instruction-sequencing control unit.
// States IDLE, T0..T6 and HALT. The outputs are a Moore decode of the current state and IR.
// Optional feature: when CU_ILLEGAL_TRAP_EN is defined, an undefined opcode traps to HALT and sets Illegal.
// In the default build an undefined opcode behaves as nop and Illegal is tied low.
module control_sequencer (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        Start,
    input  logic        Stop,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        IncPC,
    output logic        Read,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [4:0]  opcode,
    output logic        Run,
    output logic        Illegal
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    typedef enum logic [2:0] {
        C_ALU3, C_MULDIV, C_UNARY, C_NOP, C_HALT, C_ILLEGAL
    } iclass_t;

    state_t      state, next_state;
    iclass_t     iclass;
    logic [4:0]  ir_op;
    logic [15:0] sel_a, sel_b, sel_c;
    logic        ir_unused;
    state_t      end_state;

    assign ir_op = IR[31:27];
    assign sel_a = 16'd1 << IR[26:23];
    assign sel_b = 16'd1 << IR[22:19];
    assign sel_c = 16'd1 << IR[18:15];

    // IR[14:0] (immediate/address field) plays no part in sequencing.
    always_comb ir_unused = ^IR[14:0];

    // Classify the opcode into its sequencing class
    always_comb begin
        case (ir_op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: iclass = C_ALU3;
            5'b01111, 5'b10000:                     iclass = C_MULDIV;
            5'b10001, 5'b10010:                     iclass = C_UNARY;
            5'b11010:                               iclass = C_NOP;
            5'b11011:                               iclass = C_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
            default:                                iclass = C_ILLEGAL;
`else
            default:                                iclass = C_NOP;
`endif
        endcase
    end

    // State register with synchronous active-low clear
    always_ff @(posedge Clock) begin
        if (!Clear) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; Stop matters only in an instruction's final state
    always_comb begin
        end_state  = Stop ? IDLE : T0;
        next_state = state;
        case (state)
            IDLE: next_state = Start ? T0 : IDLE;
            T0:   next_state = T1;
            T1:   next_state = T2;
            T2:   next_state = T3;
            T3: begin
                case (iclass)
                    C_ALU3, C_MULDIV, C_UNARY: next_state = T4;
                    C_HALT, C_ILLEGAL:         next_state = HALT;
                    default:                   next_state = end_state;
                endcase
            end
            T4:   next_state = (iclass == C_UNARY) ? end_state : T5;
            T5:   next_state = (iclass == C_MULDIV) ? T6 : end_state;
            T6:   next_state = end_state;
            HALT: next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

`ifdef CU_ILLEGAL_TRAP_EN
    // Sticky trap flag, cleared only by Clear
    always_ff @(posedge Clock) begin
        if (!Clear)                                  Illegal <= 1'b0;
        else if (state == T3 && iclass == C_ILLEGAL) Illegal <= 1'b1;
    end
`else
    assign Illegal = 1'b0;
`endif

    // Moore output decode; every strobe defaults low
    always_comb begin
        PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
        HIout = 1'b0; LOout = 1'b0;
        MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
        Yin = 1'b0; HIin = 1'b0; LOin = 1'b0; IncPC = 1'b0; Read = 1'b0;
        Rin = '0; Rout = '0; opcode = '0;
        Run = (state != IDLE) && (state != HALT);
        case (state)
            T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1; end
            T1: begin Read = 1'b1; MDRin = 1'b1; end
            T2: begin MDRout = 1'b1; IRin = 1'b1; end
            T3: begin
                if (iclass == C_ALU3 || iclass == C_MULDIV) begin
                    Rout = sel_b; Yin = 1'b1;
                end else if (iclass == C_UNARY) begin
                    Rout = sel_b; Zin = 1'b1; opcode = ir_op;
                end
            end
            T4: begin
                if (iclass == C_UNARY) begin
                    Zlowout = 1'b1; Rin = sel_a;
                end else begin
                    Rout = sel_c; Zin = 1'b1; opcode = ir_op;
                end
            end
            T5: begin
                Zlowout = 1'b1;
                if (iclass == C_MULDIV) LOin = 1'b1;
                else                    Rin = sel_a;
            end
            T6: begin Zhighout = 1'b1; HIin = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed, table-driven check of control_sequencer.
// Each record supplies the inputs that are present at one rising edge and the outputs expected after that edge.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Clear, Start, Stop;
    logic [31:0] IR;
    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, IncPC, Read;
    logic [15:0] Rin, Rout;
    logic [4:0]  opcode;
    logic        Run, Illegal;

    control_sequencer dut (
        .Clock(Clock), .Clear(Clear), .Start(Start), .Stop(Stop), .IR(IR),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .MARin(MARin), .Zin(Zin), .PCin(PCin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
        .IncPC(IncPC), .Read(Read), .Rin(Rin), .Rout(Rout), .opcode(opcode),
        .Run(Run), .Illegal(Illegal)
    );

    always #5 Clock = ~Clock;

    // Strobe bit positions: {drive strobes, load/control strobes}
    localparam logic [15:0] PCOUT = 16'h8000, ZHI = 16'h4000, ZLO = 16'h2000, MDROUT = 16'h1000;
    localparam logic [15:0] HIOUT = 16'h0800, LOOUT = 16'h0400, MARIN = 16'h0200, ZIN = 16'h0100;
    localparam logic [15:0] PCIN = 16'h0080, MDRIN = 16'h0040, IRIN = 16'h0020, YIN = 16'h0010;
    localparam logic [15:0] HIIN = 16'h0008, LOIN = 16'h0004, INCPC = 16'h0002, READ = 16'h0001;
    localparam logic [15:0] T0S = PCOUT | MARIN | INCPC | PCIN;

    localparam logic [31:0] IR_AND  = 32'h28918000; // and R1,R2,R3
    localparam logic [31:0] IR_ROR  = 32'h53320000; // ror R6,R6,R4
    localparam logic [31:0] IR_MUL  = 32'h7A918000; // mul, Ra=5 Rb=2 Rc=3
    localparam logic [31:0] IR_NEG  = 32'h8BC80000; // neg R7,R9
    localparam logic [31:0] IR_NOP  = 32'hD0000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;
    localparam logic [31:0] IR_BAD  = 32'hF8000000; // opcode 11111

    typedef struct {
        string       name;
        logic        clear, start, stop;
        logic [31:0] ir;
        logic [15:0] strb, rin, rout;
        logic [4:0]  op;
        logic        run, ill;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input string n, input logic cl, input logic st, input logic sp,
                       input logic [31:0] ir, input logic [15:0] strb, input logic [15:0] rin,
                       input logic [15:0] rout, input logic [4:0] op, input logic run,
                       input logic ill);
        vec_t v;
        v.name = n; v.clear = cl; v.start = st; v.stop = sp; v.ir = ir;
        v.strb = strb; v.rin = rin; v.rout = rout; v.op = op; v.run = run; v.ill = ill;
        vecs.push_back(v);
    endtask

    // Apply one record across a rising edge and compare the outputs one time unit later
    task automatic apply(input vec_t v);
        logic [15:0] strb;
        logic [54:0] act, exp;
        int drives;
        Clear = v.clear; Start = v.start; Stop = v.stop; IR = v.ir;
        @(posedge Clock);
        #1;
        strb = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, MARin, Zin,
                PCin, MDRin, IRin, Yin, HIin, LOin, IncPC, Read};
        act = {strb, Rin, Rout, opcode, Run, Illegal};
        exp = {v.strb, v.rin, v.rout, v.op, v.run, v.ill};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: strb/Rin/Rout/op/Run/Ill got %h/%h/%h/%b/%b/%b want %h/%h/%h/%b/%b/%b",
                     v.name, strb, Rin, Rout, opcode, Run, Illegal,
                     v.strb, v.rin, v.rout, v.op, v.run, v.ill);
        end
        drives = $countones(Rout) + int'(PCout) + int'(Zhighout) + int'(Zlowout)
               + int'(MDRout) + int'(HIout) + int'(LOout);
        total++;
        if ($countones(Rin) > 1 || drives > 1) begin
            bad++;
            $display("FAIL %s_onehot: Rin=%h drives=%0d want <=1 bit each", v.name, Rin, drives);
        end
    endtask

    task automatic step(input string n, input logic cl, input logic st, input logic sp,
                        input logic [31:0] ir, input logic [15:0] strb, input logic [15:0] rin,
                        input logic [15:0] rout, input logic [4:0] op, input logic run,
                        input logic ill);
        vec_t v;
        v.name = n; v.clear = cl; v.start = st; v.stop = sp; v.ir = ir;
        v.strb = strb; v.rin = rin; v.rout = rout; v.op = op; v.run = run; v.ill = ill;
        apply(v);
    endtask

    initial begin
        Clear = 1'b0; Start = 1'b1; Stop = 1'b0; IR = IR_AND;

        // Reset with Start held high, then a 3-register ALU op that continues to T0
        add("rst0",     0, 1, 0, IR_AND, 16'h0,  16'h0,    16'h0,    5'h00, 0, 0);
        add("rst1",     0, 1, 0, IR_AND, 16'h0,  16'h0,    16'h0,    5'h00, 0, 0);
        add("and_t0",   1, 1, 0, IR_AND, T0S,    16'h0,    16'h0,    5'h00, 1, 0);
        add("and_t1",   1, 0, 0, IR_AND, READ | MDRIN, 16'h0, 16'h0, 5'h00, 1, 0);
        add("and_t2",   1, 0, 0, IR_AND, MDROUT | IRIN, 16'h0, 16'h0, 5'h00, 1, 0);
        add("and_t3",   1, 0, 1, IR_AND, YIN,    16'h0,    16'h0004, 5'h00, 1, 0);
        add("and_t4",   1, 0, 1, IR_AND, ZIN,    16'h0,    16'h0008, 5'h05, 1, 0);
        add("and_t5",   1, 0, 1, IR_AND, ZLO,    16'h0002, 16'h0,    5'h00, 1, 0);
        add("and_end",  1, 0, 0, IR_AND, T0S,    16'h0,    16'h0,    5'h00, 1, 0);
        // ror, with Stop during T5 returning to IDLE
        add("ror_t1",   1, 0, 0, IR_ROR, READ | MDRIN, 16'h0, 16'h0, 5'h00, 1, 0);
        add("ror_t2",   1, 0, 0, IR_ROR, MDROUT | IRIN, 16'h0, 16'h0, 5'h00, 1, 0);
        add("ror_t3",   1, 0, 0, IR_ROR, YIN,    16'h0,    16'h0040, 5'h00, 1, 0);
        add("ror_t4",   1, 0, 0, IR_ROR, ZIN,    16'h0,    16'h0010, 5'h0A, 1, 0);
        add("ror_t5",   1, 0, 0, IR_ROR, ZLO,    16'h0040, 16'h0,    5'h00, 1, 0);
        add("ror_stop", 1, 0, 1, IR_ROR, 16'h0,  16'h0,    16'h0,    5'h00, 0, 0);
        add("idle_hold",1, 0, 0, IR_ROR, 16'h0,  16'h0,    16'h0,    5'h00, 0, 0);
        // mul: seven cycles from T0 entry to the next T0 entry
        add("mul_t0",   1, 1, 0, IR_MUL, T0S,    16'h0,    16'h0,    5'h00, 1, 0);
        add("mul_t1",   1, 0, 0, IR_MUL, READ | MDRIN, 16'h0, 16'h0, 5'h00, 1, 0);
        add("mul_t2",   1, 0, 0, IR_MUL, MDROUT | IRIN, 16'h0, 16'h0, 5'h00, 1, 0);
        add("mul_t3",   1, 0, 0, IR_MUL, YIN,    16'h0,    16'h0004, 5'h00, 1, 0);
        add("mul_t4",   1, 0, 0, IR_MUL, ZIN,    16'h0,    16'h0008, 5'h0F, 1, 0);
        add("mul_t5",   1, 0, 0, IR_MUL, ZLO | LOIN, 16'h0, 16'h0,   5'h00, 1, 0);
        add("mul_t6",   1, 0, 1, IR_MUL, ZHI | HIIN, 16'h0, 16'h0,   5'h00, 1, 0);
        add("mul_end",  1, 0, 0, IR_MUL, T0S,    16'h0,    16'h0,    5'h00, 1, 0);
        // neg: five cycles
        add("neg_t1",   1, 0, 0, IR_NEG, READ | MDRIN, 16'h0, 16'h0, 5'h00, 1, 0);
        add("neg_t2",   1, 0, 0, IR_NEG, MDROUT | IRIN, 16'h0, 16'h0, 5'h00, 1, 0);
        add("neg_t3",   1, 0, 0, IR_NEG, ZIN,    16'h0,    16'h0200, 5'h11, 1, 0);
        add("neg_t4",   1, 0, 0, IR_NEG, ZLO,    16'h0080, 16'h0,    5'h00, 1, 0);
        add("neg_end",  1, 0, 0, IR_NEG, T0S,    16'h0,    16'h0,    5'h00, 1, 0);
        // nop: four cycles
        add("nop_t1",   1, 0, 0, IR_NOP, READ | MDRIN, 16'h0, 16'h0, 5'h00, 1, 0);
        add("nop_t2",   1, 0, 0, IR_NOP, MDROUT | IRIN, 16'h0, 16'h0, 5'h00, 1, 0);
        add("nop_t3",   1, 0, 0, IR_NOP, 16'h0,  16'h0,    16'h0,    5'h00, 1, 0);
        add("nop_end",  1, 0, 0, IR_NOP, T0S,    16'h0,    16'h0,    5'h00, 1, 0);
        // Undefined opcode 11111
        add("bad_t1",   1, 0, 0, IR_BAD, READ | MDRIN, 16'h0, 16'h0, 5'h00, 1, 0);
        add("bad_t2",   1, 0, 0, IR_BAD, MDROUT | IRIN, 16'h0, 16'h0, 5'h00, 1, 0);
        add("bad_t3",   1, 0, 0, IR_BAD, 16'h0,  16'h0,    16'h0,    5'h00, 1, 0);
`ifdef CU_ILLEGAL_TRAP_EN
        add("bad_halt", 1, 1, 0, IR_BAD, 16'h0,  16'h0,    16'h0,    5'h00, 0, 1);
        add("bad_hold0",1, 1, 0, IR_BAD, 16'h0,  16'h0,    16'h0,    5'h00, 0, 1);
        add("bad_hold1",1, 1, 0, IR_BAD, 16'h0,  16'h0,    16'h0,    5'h00, 0, 1);
`else
        add("bad_end",  1, 0, 0, IR_BAD, T0S,    16'h0,    16'h0,    5'h00, 1, 0);
        add("bad_next", 1, 0, 0, IR_BAD, READ | MDRIN, 16'h0, 16'h0, 5'h00, 1, 0);
`endif

        foreach (vecs[i]) apply(vecs[i]);

        // Clear from whatever state the table left (HALT or mid-instruction)
        step("clr_a",    0, 1, 0, IR_HALT, 16'h0, 16'h0, 16'h0, 5'h00, 0, 0);
        step("clr_b",    0, 0, 0, IR_HALT, 16'h0, 16'h0, 16'h0, 5'h00, 0, 0);

        // halt instruction: HALT ignores Start and Stop until Clear
        step("halt_t0",  1, 1, 0, IR_HALT, T0S, 16'h0, 16'h0, 5'h00, 1, 0);
        step("halt_t1",  1, 0, 0, IR_HALT, READ | MDRIN, 16'h0, 16'h0, 5'h00, 1, 0);
        step("halt_t2",  1, 0, 0, IR_HALT, MDROUT | IRIN, 16'h0, 16'h0, 5'h00, 1, 0);
        step("halt_t3",  1, 0, 0, IR_HALT, 16'h0, 16'h0, 16'h0, 5'h00, 1, 0);
        step("halt_in",  1, 1, 0, IR_HALT, 16'h0, 16'h0, 16'h0, 5'h00, 0, 0);
        for (int k = 0; k < 3; k++)
            step("halt_hold", 1, 1, 1, IR_AND, 16'h0, 16'h0, 16'h0, 5'h00, 0, 0);
        step("halt_clr", 0, 1, 0, IR_AND, 16'h0, 16'h0, 16'h0, 5'h00, 0, 0);

        // Clear during T4 aborts the instruction; Zin must not follow
        step("ab_t0",    1, 1, 0, IR_AND, T0S, 16'h0, 16'h0, 5'h00, 1, 0);
        step("ab_t1",    1, 0, 0, IR_AND, READ | MDRIN, 16'h0, 16'h0, 5'h00, 1, 0);
        step("ab_t2",    1, 0, 0, IR_AND, MDROUT | IRIN, 16'h0, 16'h0, 5'h00, 1, 0);
        step("ab_t3",    1, 0, 0, IR_AND, YIN, 16'h0, 16'h0004, 5'h00, 1, 0);
        step("ab_t4",    1, 0, 0, IR_AND, ZIN, 16'h0, 16'h0008, 5'h05, 1, 0);
        step("ab_clr",   0, 0, 0, IR_AND, 16'h0, 16'h0, 16'h0, 5'h00, 0, 0);
        step("ab_restart", 1, 1, 0, IR_AND, T0S, 16'h0, 16'h0, 5'h00, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
